scale_fetch: RTL and testbench
==============================

Name: scale_fetch

Overview:
- Upstream feeder for the 2x2 scaling stage.
- Walks the source image in scaling-block order and issues reads to the single-port frame SRAM (1-cycle read latency).
- Presents pixels A,B,C,D on pix_out in exactly the cycles the scaling stage consumes them, and drives that stage's enable.
- Owns slot alignment with the scaling stage, including recovery after a 200 ms tick forces the scaling stage into write-back.

Parameters:
- ADDR_W, 18, SRAM word-address width (512*512 words).
- SRC_BASE, 0, word address of source pixel (0,0).
- W_SMALL, 128, source width/height in expand mode.
- W_LARGE, 512, source width/height in compress mode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored while busy.
- process_mode  in  1  0 = expand (128 src, stride 1), 1 = compress (512 src, stride 2); sampled on accepted start.
- clk_200ms  in  1  same tick the scaling stage sees.
- rd_data  in  24  SRAM read data; valid the cycle after rd_en.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_W  SRAM read address.
- pix_out  out  24  registered pixel to the scaling stage's pixel_in.
- scl_en  out  1  scaling-stage enable.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, counters cleared. Reset mid-frame aborts immediately with no done.
- FSM states: IDLE -> ARM -> RUN -> (RESYNC -> RUN)* -> FINISH -> IDLE.
- Accepted start: busy=1 next cycle; state ARM; scl_en=1 from the following cycle, called cycle E.
- Scaling stage timeline from E: NOP at E, INIT at E+1.
- Block period P: 7 in expand (INIT,A,B,C,D,WB1,WB2), 6 in compress (INIT,A,B,C,D,WB2).
- Block k: A at E+2+kP, B at E+3+kP, C at E+4+kP, D at E+5+kP.
- pix_out: pix_out <= rd_data, so rd_addr/rd_en for a slot-s pixel are issued in cycle s-2. rd_en=1 only for those four issue cycles per block. pix_out is held in non-pixel slots.
- Block origin, expand: (r,c) over 128x128, raster, c fastest; 16384 blocks.
- Block origin, compress: (2r,2c) over 512x512; 65536 blocks.
- Pixel positions: A=(y,x), B=(y,x+1), C=(y+1,x), D=(y+1,x+1).
- Address: SRC_BASE + y*W + x; W = W_SMALL or W_LARGE. Built with shifts only (W power of two); no multiplier.
- Edge clamp (expand only): x+1 > 127 uses x; y+1 > 127 uses y. Compress never exceeds bounds.
- Tick: clk_200ms=1 sampled at the end of cycle t forces state RESYNC and abandons the current block without advancing the block counter.
  - Scaling sees WB1 t+1, WB2 t+2, INIT t+3.
  - Block then restarts with A at t+4; its reads issue from t+2.
  - A tick during RESYNC restarts the same alignment from the new t.
  - A tick in the last block re-fetches that block.
  - Tick is ignored in IDLE/FINISH.
- Frame end: after WB slot of last block (expand E+7+7*16383, compress E+6+6*65535), next cycle FINISH.
  - FINISH: done=1, scl_en=0, busy=0 in the same cycle; then IDLE.
- start coincident with done is ignored; start is accepted from IDLE only.
- process_mode changes mid-frame have no effect.

Optional Feature:
- Macro SCALE_FETCH_ZERO_PAD_EN.
- Defined: expand-mode out-of-range neighbours are 24'h000000. No read is issued for them (rd_en=0 in that issue cycle) and pix_out is forced to 0 in that slot.
- Undefined: edge clamp as above.

Test Plan:
- Compress, SRC_BASE=0, start -> block 0 rd_addr 0,1,512,513 in cycles E+0..E+3; block 1 rd_addr 2,3,514,515 starting E+6; pix_out equals SRAM contents at E+2..E+5.
- Expand, block (r=5,c=127) -> addresses 767,767,895,895 (clamped); with SCALE_FETCH_ZERO_PAD_EN: 767, no-read, 895, no-read, with pix_out B and D = 0.
- Expand, clk_200ms pulse during slot C of block 10 -> scl_en stays 1; block 10 re-fetched with A at t+4; total frame length grows by exactly the abandoned partial block plus 3 cycles.
- Expand full frame -> done single pulse at E+8+7*16383; busy falls same cycle; scl_en 0 thereafter; start during busy has no effect.
- rst_n low for 1 cycle mid-frame (compress, block 300) -> all outputs 0 asynchronously, no done; new start runs a full frame from block 0.
- start asserted in same cycle as done -> ignored; subsequent start pulse accepted normally.

Source files
------------

// File: rtl/scale_fetch.sv
// Feeds the 2x2 scaling stage: walks source blocks, reads the frame SRAM,
// aligns pixel slots. Optional SCALE_FETCH_ZERO_PAD_EN zero-pads expand edges.
module scale_fetch #(
  parameter int ADDR_W   = 18,
  parameter int SRC_BASE = 0,
  parameter int W_SMALL  = 128,
  parameter int W_LARGE  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              process_mode,
  input  logic              clk_200ms,
  input  logic [23:0]       rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       pix_out,
  output logic              scl_en,
  output logic              busy,
  output logic              done
);

  localparam int LS = $clog2(W_SMALL);
  localparam int LL = $clog2(W_LARGE);
  localparam int NS = W_SMALL * W_SMALL;
  localparam int NL = (W_LARGE / 2) * (W_LARGE / 2);
  localparam int NM = (NL > NS) ? NL : NS;
  localparam int BW = $clog2(NM + 1);

`ifdef SCALE_FETCH_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ARM, RUN, RESYNC, FINISH
  } state_t;

  state_t state, state_n;

  logic          mode;
  logic [2:0]    ph, ph_n, plast;
  logic [BW-1:0] blk, blk_n, nblk;
  logic          tail;
  logic          issue;
  logic          rd_v, pad_v;

  logic [ADDR_W-1:0] row, col, x, y, addr;
  logic              dx, dy, ex, ey, pad;

  assign nblk  = mode ? BW'(NL) : BW'(NS);
  assign plast = mode ? 3'd5 : 3'd6;
  assign tail  = (blk == nblk);
  assign dx    = ph[0];
  assign dy    = ph[1];

  // Block index -> pixel coordinate; W is a power of two so shifts suffice
  always_comb begin
    row  = '0;
    col  = '0;
    x    = '0;
    y    = '0;
    ex   = 1'b0;
    ey   = 1'b0;
    addr = '0;
    if (mode) begin
      col  = ADDR_W'(blk & BW'(W_LARGE / 2 - 1));
      row  = ADDR_W'(blk >> (LL - 1));
      x    = (col << 1) | ADDR_W'(dx);
      y    = (row << 1) | ADDR_W'(dy);
      addr = ADDR_W'(SRC_BASE) + (y << LL) + x;
    end else begin
      col = ADDR_W'(blk & BW'(W_SMALL - 1));
      row = ADDR_W'(blk >> LS);
      x   = col;
      y   = row;
      if (dx && col == ADDR_W'(W_SMALL - 1)) ex = 1'b1;
      else x = col + ADDR_W'(dx);
      if (dy && row == ADDR_W'(W_SMALL - 1)) ey = 1'b1;
      else y = row + ADDR_W'(dy);
      addr = ADDR_W'(SRC_BASE) + (y << LS) + x;
    end
  end

  assign pad     = PAD && (ex || ey);
  assign issue   = (state == RUN) && !tail && (ph < 3'd4);
  assign rd_en   = issue && !pad;
  assign rd_addr = rd_en ? addr : '0;

  assign busy   = (state == ARM) || (state == RUN)
               || (state == RESYNC);
  assign scl_en = (state == RUN) || (state == RESYNC);
  assign done   = (state == FINISH);

  always_comb begin
    state_n = state;
    ph_n    = ph;
    blk_n   = blk;
    unique case (state)
      IDLE: begin
        ph_n  = '0;
        blk_n = '0;
        if (start) state_n = ARM;
      end
      ARM: begin
        ph_n    = '0;
        state_n = clk_200ms ? RESYNC : RUN;
      end
      RUN: begin
        if (clk_200ms) begin
          state_n = RESYNC;
          ph_n    = '0;
          if (tail) blk_n = blk - BW'(1);
        end else if (tail) begin
          state_n = FINISH;
        end else if (ph == plast) begin
          ph_n  = '0;
          blk_n = blk + BW'(1);
        end else begin
          ph_n = ph + 3'd1;
        end
      end
      RESYNC: begin
        ph_n = '0;
        if (!clk_200ms) state_n = RUN;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ph      <= '0;
      blk     <= '0;
      mode    <= 1'b0;
      rd_v    <= 1'b0;
      pad_v   <= 1'b0;
      pix_out <= '0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      blk   <= blk_n;
      if (state == IDLE && start) mode <= process_mode;
      rd_v  <= rd_en;
      pad_v <= issue && pad;
      // Pixel slots only; pix_out holds through INIT/WB
      if (pad_v) pix_out <= '0;
      else if (rd_v) pix_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_scale_fetch.sv
// Bench for scale_fetch: time-based block schedule model, hashed SRAM,
// random ticks and mode toggling, reset abort and done/start overlap.
module tb_scale_fetch;

  localparam int AW   = 18;
  localparam int BASE = 64;
  localparam int WS   = 16;
  localparam int WL   = 32;
  localparam int NS   = WS * WS;
  localparam int NL   = (WL / 2) * (WL / 2);

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          process_mode = 0;
  logic          clk_200ms = 0;
  logic [23:0]   rd_data = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   pix_out;
  logic          scl_en;
  logic          busy;
  logic          done;

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] seed;

  scale_fetch #(
    .ADDR_W(AW), .SRC_BASE(BASE),
    .W_SMALL(WS), .W_LARGE(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .process_mode(process_mode),
    .clk_200ms(clk_200ms), .rd_data(rd_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .pix_out(pix_out), .scl_en(scl_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sram(input logic [AW-1:0] a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ seed;
    return h[23:0];
  endfunction

  // 1-cycle latency SRAM; junk when not read
  always @(posedge clk)
    rd_data <= rd_en ? sram(rd_addr) : 24'($urandom);

  function automatic int ref_addr(input bit m, input int b,
                                  input int p, output bit pad);
    int w, r, c, x, y;
    pad = 0;
    if (m) begin
      w = WL; r = b / (WL / 2); c = b % (WL / 2);
      x = 2 * c + p % 2; y = 2 * r + p / 2;
    end else begin
      w = WS; r = b / WS; c = b % WS;
      x = c + p % 2; y = r + p / 2;
      if (x > WS - 1) begin x = c; pad = 1; end
      if (y > WS - 1) begin y = r; pad = 1; end
    end
`ifndef SCALE_FETCH_ZERO_PAD_EN
    pad = 0;
`endif
    return BASE + y * w + x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed %0h expected %0h",
             tag, $time, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_scl"}, 32'(scl_en), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd"}, 32'(rd_en), 0);
    chk({tag, "_addr"}, 32'(rd_addr), 0);
    chk({tag, "_pix"}, 32'(pix_out), 0);
  endtask

  // Times n are relative to E; block b fetches at bs..bs+3,
  // pixels at bs+2..bs+5; a tick at n restarts fetch at n+2.
  task automatic frame(input bit m, input int t0, input int t1,
                       input int t2, input int bstart,
                       input int abort_at, input bit sod,
                       input int exp_len);
    int N, P, b, bs, off, a, fin_n;
    bit tk, fin, pad, aborted;
    N = m ? NL : NS;
    P = m ? 6 : 7;
    b = 0; bs = 0; fin_n = -1; aborted = 0;
    start = 1; process_mode = m;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    start = 0; process_mode = ~m;
    @(negedge clk);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_scl", 32'(scl_en), 0);
    chk("arm_rd", 32'(rd_en), 0);
    @(posedge clk); #1;
    for (int n = 0; n < 20000 && fin_n < 0 && !aborted; n++) begin
      off = n - bs;
      fin = (b == N && off == 1);
      tk = (n == t0) || (n == t1) || (n == t2);
      clk_200ms = tk;
      start = (n == bstart) || (fin && sod);
      process_mode = 1'($urandom);
      if (n == abort_at) begin
        rst_n = 0; #1;
        chk_zero("abort");
        @(posedge clk); #1;
        rst_n = 1;
        aborted = 1;
      end else begin
        @(negedge clk);
        chk("busy", 32'(busy), 32'(!fin));
        chk("scl_en", 32'(scl_en), 32'(!fin));
        chk("done", 32'(done), 32'(fin));
        if (off >= 0 && off < 4 && b < N) begin
          a = ref_addr(m, b, off, pad);
          chk("rd_en", 32'(rd_en), 32'(!pad));
          if (!pad) chk("rd_addr", 32'(rd_addr), 32'(a));
        end else begin
          chk("rd_idle", 32'(rd_en), 0);
        end
        if (off >= 2 && off <= 5 && b < N) begin
          a = ref_addr(m, b, off - 2, pad);
          chk("pix", 32'(pix_out),
              pad ? 32'h0 : 32'(sram(AW'(a))));
        end
        @(posedge clk); #1;
        if (fin) fin_n = n;
        else if (tk) begin
          bs = n + 2;
          if (b == N) b = N - 1;
        end else if (b < N && off == P - 1) begin
          b++;
          bs += P;
        end
      end
    end
    clk_200ms = 0;
    start = 0;
    if (!aborted) begin
      chk("frame_end", 32'(fin_n >= 0), 1);
      if (exp_len >= 0) chk("frame_len", 32'(fin_n), 32'(exp_len));
    end
    repeat (2) begin
      @(negedge clk);
      chk("post_busy", 32'(busy), 0);
      chk("post_done", 32'(done), 0);
      chk("post_scl", 32'(scl_en), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int ta, tb2;
    seed = $urandom;
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    // compress, start while busy
    frame(1, -1, -1, -1, 50, -1, 0, 6 * NL + 1);
    // expand, tick in slot C of block 10, start on done
    frame(0, 74, -1, -1, 300, -1, 1, 7 * NS + 1 + 6);
    // expand, random tick pair (second lands in RESYNC) plus one more
    ta  = $urandom_range(10, 7 * NS - 60);
    tb2 = $urandom_range(ta + 20, 7 * NS - 10);
    frame(0, ta, ta + 1, tb2, -1, -1, 0, -1);
    // compress, tick in last block
    frame(1, 6 * (NL - 1) + 2, -1, -1, -1, -1, 0, 6 * NL + 1 + 4);
    // compress, reset at block 100, then full frame
    frame(1, -1, -1, -1, -1, 6 * 100 + 2, 0, -1);
    frame(1, -1, -1, -1, -1, -1, 0, 6 * NL + 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
